// File: rtl/multicycle_adder_if.sv
// Request/result bundle for multicycle_adder: operands and start from the
// requester, busy/done and the registered result back from the adder.
interface multicycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/multicycle_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock over N = WIDTH/DIGIT
// cycles, then publishes sum, carry_out and signed overflow with a done pulse.
// Operands are shifted down each cycle so the active chunk always sits in the
// low DIGIT bits; partial sums enter the shadow register from the top.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_adder_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("multicycle_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 last;
  logic [CNT_W-1:0]     chunk_idx;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 carry;
  logic [WIDTH-1:0]     shadow;
  logic [DIGIT:0]       chunk_sum;
  logic [WIDTH+DIGIT-1:0] shadow_cat;
  logic [WIDTH-1:0]     sum_q;
  logic                 carry_out_q;
  logic                 overflow_q;
  logic                 done_q;

  // State register; reset drops straight back to IDLE, aborting any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus accept/last strobes; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (chunk_idx == LAST_CHUNK) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One DIGIT-wide slice addition and the shadow value after inserting it.
  always_comb begin
    chunk_sum  = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry};
    shadow_cat = {chunk_sum[DIGIT-1:0], shadow};
  end

  // Operand latching on accept, then one chunk consumed per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      shadow    <= '0;
      chunk_idx <= '0;
    end else if (accept) begin
      op_a      <= bus.a;
      op_b      <= bus.sub ? ~bus.b : bus.b;
      carry     <= bus.sub | bus.c_in;
      shadow    <= '0;
      chunk_idx <= '0;
    end else if (state == RUN) begin
      op_a      <= op_a >> DIGIT;
      op_b      <= op_b >> DIGIT;
      carry     <= chunk_sum[DIGIT];
      shadow    <= shadow_cat[WIDTH+DIGIT-1:DIGIT];
      chunk_idx <= chunk_idx + 1'b1;
    end
  end

  // Result registers update only on the final chunk and hold otherwise;
  // on that chunk the operand MSBs are the top bits of the low slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= last;
      if (last) begin
        sum_q       <= shadow_cat[WIDTH+DIGIT-1:DIGIT];
        carry_out_q <= chunk_sum[DIGIT];
        overflow_q  <= (op_a[DIGIT-1] == op_b[DIGIT-1])
                    && (chunk_sum[DIGIT-1] != op_a[DIGIT-1]);
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three instances (8/2, 8/8, 32/4) against a
// cycle-level reference model, plus literal checks of known results.
module tb_multicycle_adder;

  logic clk;
  logic rst_n;

  logic [31:0] a_d   [3];
  logic [31:0] b_d   [3];
  logic        start_d [3];
  logic        sub_d [3];
  logic        cin_d [3];

  logic        busy_o [3];
  logic        done_o [3];
  logic [31:0] sum_o  [3];
  logic        cout_o [3];
  logic        ovf_o  [3];

  int compared;
  int mismatched;

  multicycle_adder_if #(.WIDTH(8))  bus0 ();
  multicycle_adder_if #(.WIDTH(8))  bus1 ();
  multicycle_adder_if #(.WIDTH(32)) bus2 ();

  multicycle_adder #(.WIDTH(8),  .DIGIT(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_adder #(.WIDTH(8),  .DIGIT(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  multicycle_adder #(.WIDTH(32), .DIGIT(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.start = start_d[0];  assign bus0.sub = sub_d[0];  assign bus0.c_in = cin_d[0];
  assign bus0.a = a_d[0][7:0];     assign bus0.b = b_d[0][7:0];
  assign bus1.start = start_d[1];  assign bus1.sub = sub_d[1];  assign bus1.c_in = cin_d[1];
  assign bus1.a = a_d[1][7:0];     assign bus1.b = b_d[1][7:0];
  assign bus2.start = start_d[2];  assign bus2.sub = sub_d[2];  assign bus2.c_in = cin_d[2];
  assign bus2.a = a_d[2];          assign bus2.b = b_d[2];

  assign busy_o[0] = bus0.busy;  assign done_o[0] = bus0.done;  assign sum_o[0] = {24'd0, bus0.sum};
  assign cout_o[0] = bus0.carry_out;  assign ovf_o[0] = bus0.overflow;
  assign busy_o[1] = bus1.busy;  assign done_o[1] = bus1.done;  assign sum_o[1] = {24'd0, bus1.sum};
  assign cout_o[1] = bus1.carry_out;  assign ovf_o[1] = bus1.overflow;
  assign busy_o[2] = bus2.busy;  assign done_o[2] = bus2.done;  assign sum_o[2] = bus2.sum;
  assign cout_o[2] = bus2.carry_out;  assign ovf_o[2] = bus2.overflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res_t;

  function automatic int wOf(input int k);
    return (k == 2) ? 32 : 8;
  endfunction

  function automatic int nOf(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
  endfunction

  // Reference arithmetic: unsigned result modulo 2^w, signed range check
  function automatic res_t refOp(input int w, input logic sub, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    res_t   r;
    longint m    = (longint'(1) << w);
    longint ua   = longint'(a) & (m - 1);
    longint ub   = longint'(b) & (m - 1);
    longint half = m / 2;
    longint sa   = (ua >= half) ? ua - m : ua;
    longint sb   = (ub >= half) ? ub - m : ub;
    longint us;
    longint ss;
    if (sub) begin
      us   = (ua - ub) & (m - 1);
      r.co = (ua >= ub);
      ss   = sa - sb;
    end else begin
      us   = ua + ub + longint'(cin);
      r.co = (us >= m);
      us   = us & (m - 1);
      ss   = sa + sb + longint'(cin);
    end
    r.s  = 32'(us);
    r.ov = (ss >= half) || (ss < -half);
    return r;
  endfunction

  int   m_cnt  [3];
  res_t m_pend [3];
  res_t m_out  [3];
  logic m_done [3];

  // Model: accepted op counts down N cycles, then publishes with a done pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k]  <= 0;
        m_out[k]  <= '0;
        m_pend[k] <= '0;
        m_done[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_done[k] <= 1'b0;
        if (m_cnt[k] > 0) begin
          m_cnt[k] <= m_cnt[k] - 1;
          if (m_cnt[k] == 1) begin
            m_out[k]  <= m_pend[k];
            m_done[k] <= 1'b1;
          end
        end else if (start_d[k]) begin
          m_pend[k] <= refOp(wOf(k), sub_d[k], a_d[k], b_d[k], cin_d[k]);
          m_cnt[k]  <= nOf(k);
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every instance against the model on each falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("inst%0d busy", k), 32'(busy_o[k]), 32'(m_cnt[k] > 0));
      checkOutput($sformatf("inst%0d done", k), 32'(done_o[k]), 32'(m_done[k]));
      checkOutput($sformatf("inst%0d sum", k),  sum_o[k],        m_out[k].s);
      checkOutput($sformatf("inst%0d cout", k), 32'(cout_o[k]),  32'(m_out[k].co));
      checkOutput($sformatf("inst%0d ovf", k),  32'(ovf_o[k]),   32'(m_out[k].ov));
    end
  end

  task automatic applyStimulus(input int k, input logic st, input logic sb,
                               input logic [31:0] a, input logic [31:0] b, input logic ci);
    start_d[k] = st;
    sub_d[k]   = sb;
    a_d[k]     = a;
    b_d[k]     = b;
    cin_d[k]   = ci;
  endtask

  // One directed op on the 8/2 instance; operands are scrambled after accept
  task automatic runOp(input string nm, input logic sb, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] es, input logic ec, input logic eo);
    logic got;
    @(negedge clk);
    applyStimulus(0, 1'b1, sb, {24'd0, a}, {24'd0, b}, ci);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom));
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      if (done_o[0]) got = 1'b1;
      else @(negedge clk);
    end
    checkOutput({nm, " done seen"}, 32'(got), 32'd1);
    if (got) begin
      checkOutput({nm, " sum"},  sum_o[0],       {24'd0, es});
      checkOutput({nm, " cout"}, 32'(cout_o[0]), 32'(ec));
      checkOutput({nm, " ovf"},  32'(ovf_o[0]),  32'(eo));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    #1;
    checkOutput("reset busy", 32'(busy_o[0]), 32'd0);
    checkOutput("reset done", 32'(done_o[0]), 32'd0);
    checkOutput("reset sum",  sum_o[0],       32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    runOp("add 5A+3C+1", 1'b0, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1);
    runOp("add FF+01",   1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runOp("add 7F+01",   1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    runOp("sub 10-20",   1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    runOp("sub 80-01",   1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    $display("[TB] back-to-back with start held high");
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'($urandom), $urandom, $urandom, 1'($urandom));
    end
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    $display("[TB] random traffic on all instances");
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        applyStimulus(k, 1'($urandom_range(0, 2) == 0), 1'($urandom), $urandom, $urandom, 1'($urandom));
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (10) @(negedge clk);

    $display("[TB] reset during RUN");
    runOp("pre-reset add", 1'b0, 8'h40, 8'h21, 1'b0, 8'h61, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h33, 32'h44, 1'b0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy_o[0]), 32'd0);
    checkOutput("abort done", 32'(done_o[0]), 32'd0);
    checkOutput("abort sum",  sum_o[0],       32'd0);
    checkOutput("abort cout", 32'(cout_o[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    runOp("post-reset add", 1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
